multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TimeoutCycles, default 16: max consecutive wait cycles on one memory request before trap; legal range 1..255.
REQ-002 Parameter InstretWidth, default 32: width of the retired-instruction counter.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 op_code_i  input  7  opcode field of the instruction register.
REQ-006 mem_ready_i  input  1  memory completes the current request this cycle.
REQ-007 branch_taken_i  input  1  datapath branch-compare result, valid in EXECUTE.
REQ-008 mem_req_o, mem_wr_en_o  output  1 each  memory request and write qualifier.
REQ-009 addr_sel_o  output  1  memory address source: 0 = PC, 1 = ALU result register.
REQ-010 ir_wr_en_o, pc_wr_en_o, regf_wr_en_o  output  1 each  register write enables.
REQ-011 pc_src_o  output  1  next-PC source: 0 = PC+4, 1 = ALU target.
REQ-012 alu_src1_sel_o, alu_src2_sel_o, regf_rd_src_o  output  2 each  source selects; encodings per REQ-028.
REQ-013 retire_o  output  1  one-cycle pulse per completed instruction.
REQ-014 instret_o  output  InstretWidth  retired-instruction count.
REQ-015 trap_o, bus_err_o  output  1 each  sticky trap; bus_err_o set only for timeout traps.

Function
REQ-016 States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP; all outputs are decoded from state plus the opcode latched in DECODE.
REQ-017 FETCH: mem_req_o=1, addr_sel_o=0; hold until mem_ready_i=1, then in that cycle assert ir_wr_en_o, pc_wr_en_o, pc_src_o=0; next state DECODE.
REQ-018 DECODE: latch op_code_i; unrecognised opcode -> TRAP (bus_err_o stays 0); otherwise -> EXECUTE.
REQ-019 EXECUTE by class: OP/OP-IMM/LUI/AUIPC -> WRITEBACK; LOAD/STORE -> MEMORY (address computed); BRANCH: pc_wr_en_o=branch_taken_i, pc_src_o=1, retire, -> FETCH; JAL/JALR: pc_wr_en_o=1, pc_src_o=1, -> WRITEBACK.
REQ-020 MEMORY: mem_req_o=1, addr_sel_o=1, mem_wr_en_o=1 for STORE only; hold until mem_ready_i; STORE retires and -> FETCH, LOAD -> WRITEBACK.
REQ-021 WRITEBACK: regf_wr_en_o=1 with regf_rd_src_o = mem (LOAD), PC+4 (JAL/JALR), ALU (others); retire; -> FETCH.
REQ-022 Zero-wait latencies (mem_ready_i always 1): BRANCH 3, STORE/ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5 cycles.
REQ-023 Wait counter counts cycles with mem_req_o=1 and mem_ready_i=0, clears on any completed request or state change.
REQ-024 Counter reaching TimeoutCycles while mem_ready_i=0 -> TRAP next cycle with bus_err_o=1; mem_ready_i=1 in that same cycle wins (request completes, no trap).
REQ-025 TRAP is absorbing until reset: all enables and mem_req_o = 0, trap_o=1.
REQ-026 instret_o increments by 1 on each retire_o pulse, wraps modulo 2^InstretWidth.
REQ-027 mem_wr_en_o is never 1 while mem_req_o is 0; at most one of ir_wr_en_o/regf_wr_en_o is 1 per cycle.
REQ-028 Encodings: alu_src1 0=rs1,1=PC,2=zero; alu_src2 0=rs2,1=imm,2=const4; regf_rd_src 0=ALU,1=mem,2=PC+4; 3 unused in all.

Reset
REQ-029 rst_ni=0 forces state FETCH, wait counter 0, instret_o 0, trap_o 0, bus_err_o 0, latched opcode 0 immediately, regardless of clock.
REQ-030 During reset all enables and mem_req_o are 0; reset asserted mid-request abandons it with no retire.
REQ-031 First rising edge after rst_ni deassertion begins FETCH with mem_req_o=1.

Structure
REQ-032 Shared package mc_pkg holds the state enum, RV32I opcode constants and the select encodings of REQ-028.
REQ-033 One sub-module, mc_wait_timer, implements the wait counter and timeout flag, parameterised by TimeoutCycles.

Verification
REQ-034 ADD (0110011), mem_ready_i=1 -> states F,D,E,W; regf_wr_en_o=1 with regf_rd_src_o=0 in cycle 4; retire_o once; instret_o=1.
REQ-035 LOAD with 2 wait cycles in FETCH and MEMORY -> 9 cycles total; regf_rd_src_o=1 in WRITEBACK.
REQ-036 BRANCH, branch_taken_i=0 then 1 -> pc_wr_en_o 0 then 1 in EXECUTE; 3 cycles each; instret_o=2.
REQ-037 TimeoutCycles=4, mem_ready_i held 0 in FETCH -> TRAP after 4 wait cycles, trap_o=bus_err_o=1, outputs idle; ready on 4th wait cycle -> no trap.
REQ-038 Opcode 0000000 -> TRAP after DECODE, bus_err_o=0; then rst_ni pulse mid-cycle -> immediate FETCH, instret_o=0.
REQ-039 InstretWidth=4, 17 back-to-back ADDs -> instret_o wraps to 1.

Source files
------------

// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_pkg: shared states, RV32I opcodes and datapath select encodings    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_TRAP      = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CLS_OP      = 4'd0,
      CLS_OPIMM   = 4'd1,
      CLS_LUI     = 4'd2,
      CLS_AUIPC   = 4'd3,
      CLS_LOAD    = 4'd4,
      CLS_STORE   = 4'd5,
      CLS_BRANCH  = 4'd6,
      CLS_JAL     = 4'd7,
      CLS_JALR    = 4'd8,
      CLS_ILLEGAL = 4'd9
   } op_class_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [1:0] ALU1_RS1    = 2'd0;
   localparam logic [1:0] ALU1_PC     = 2'd1;
   localparam logic [1:0] ALU1_ZERO   = 2'd2;
   localparam logic [1:0] ALU2_RS2    = 2'd0;
   localparam logic [1:0] ALU2_IMM    = 2'd1;
   localparam logic [1:0] ALU2_CONST4 = 2'd2;
   localparam logic [1:0] RD_SRC_ALU  = 2'd0;
   localparam logic [1:0] RD_SRC_MEM  = 2'd1;
   localparam logic [1:0] RD_SRC_PC4  = 2'd2;

   // Wide enough for the largest legal timeout (255)
   localparam int unsigned WAIT_CNT_W = 8;

   function automatic op_class_e classify(input logic [6:0] opc);
      op_class_e cls;
      case (opc)
         OPC_OP:     cls = CLS_OP;
         OPC_OPIMM:  cls = CLS_OPIMM;
         OPC_LUI:    cls = CLS_LUI;
         OPC_AUIPC:  cls = CLS_AUIPC;
         OPC_LOAD:   cls = CLS_LOAD;
         OPC_STORE:  cls = CLS_STORE;
         OPC_BRANCH: cls = CLS_BRANCH;
         OPC_JAL:    cls = CLS_JAL;
         OPC_JALR:   cls = CLS_JALR;
         default:    cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_wait_timer: counts stalled memory-request cycles, flags timeout    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mc_wait_timer
   import mc_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_i,
   input  logic ready_i,
   output logic timeout_o
);

   localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(TimeoutCycles - 1);

   logic [WAIT_CNT_W-1:0] count_q;
   logic [WAIT_CNT_W-1:0] count_d;
   logic                  w_waiting;

   assign w_waiting = req_i & ~ready_i;
   // Timeout fires on the cycle that would be the TimeoutCycles-th stalled one
   assign timeout_o = w_waiting & (count_q == LAST_WAIT);
   assign count_d   = (w_waiting && !timeout_o) ? count_q + 1'b1 : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_controller: RV32I multi-cycle control FSM with bus timeout |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 16,
   parameter int unsigned InstretWidth  = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [6:0]              op_code_i,
   input  logic                    mem_ready_i,
   input  logic                    branch_taken_i,
   output logic                    mem_req_o,
   output logic                    mem_wr_en_o,
   output logic                    addr_sel_o,
   output logic                    ir_wr_en_o,
   output logic                    pc_wr_en_o,
   output logic                    regf_wr_en_o,
   output logic                    pc_src_o,
   output logic [1:0]              alu_src1_sel_o,
   output logic [1:0]              alu_src2_sel_o,
   output logic [1:0]              regf_rd_src_o,
   output logic                    retire_o,
   output logic [InstretWidth-1:0] instret_o,
   output logic                    trap_o,
   output logic                    bus_err_o
);

   state_e                  state_q;
   logic [6:0]              opcode_q;
   logic                    trap_q;
   logic                    bus_err_q;
   logic [InstretWidth-1:0] instret_q;

   op_class_e  w_cls;
   logic       w_timeout;
   logic       w_mem_req;
   logic       w_mem_wr;
   logic       w_addr_sel;
   logic       w_ir_wr;
   logic       w_pc_wr;
   logic       w_regf_wr;
   logic       w_pc_src;
   logic [1:0] w_alu1;
   logic [1:0] w_alu2;
   logic [1:0] w_rd_src;
   logic       w_retire;

   assign w_cls = classify(opcode_q);

   mc_wait_timer #(
      .TimeoutCycles (TimeoutCycles)
   ) u_wait_timer (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (w_mem_req),
      .ready_i   (mem_ready_i),
      .timeout_o (w_timeout)
   );

   always_comb begin
      w_mem_req  = 1'b0;
      w_mem_wr   = 1'b0;
      w_addr_sel = 1'b0;
      w_ir_wr    = 1'b0;
      w_pc_wr    = 1'b0;
      w_regf_wr  = 1'b0;
      w_pc_src   = 1'b0;
      w_alu1     = ALU1_RS1;
      w_alu2     = ALU2_RS2;
      w_rd_src   = RD_SRC_ALU;
      w_retire   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            w_mem_req = 1'b1;
            w_alu1    = ALU1_PC;
            w_alu2    = ALU2_CONST4;
            if (mem_ready_i) begin
               w_ir_wr = 1'b1;
               w_pc_wr = 1'b1;
            end
         end
         ST_EXECUTE: begin
            case (w_cls)
               CLS_OP:     ;
               CLS_OPIMM:  w_alu2 = ALU2_IMM;
               CLS_LUI: begin
                  w_alu1 = ALU1_ZERO;
                  w_alu2 = ALU2_IMM;
               end
               CLS_AUIPC: begin
                  w_alu1 = ALU1_PC;
                  w_alu2 = ALU2_IMM;
               end
               CLS_LOAD, CLS_STORE: w_alu2 = ALU2_IMM;
               CLS_BRANCH: begin
                  w_alu1   = ALU1_PC;
                  w_alu2   = ALU2_IMM;
                  w_pc_wr  = branch_taken_i;
                  w_pc_src = 1'b1;
                  w_retire = 1'b1;
               end
               CLS_JAL: begin
                  w_alu1   = ALU1_PC;
                  w_alu2   = ALU2_IMM;
                  w_pc_wr  = 1'b1;
                  w_pc_src = 1'b1;
               end
               CLS_JALR: begin
                  w_alu2   = ALU2_IMM;
                  w_pc_wr  = 1'b1;
                  w_pc_src = 1'b1;
               end
               default: ;
            endcase
         end
         ST_MEMORY: begin
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            w_mem_wr   = (w_cls == CLS_STORE);
            w_retire   = mem_ready_i && (w_cls == CLS_STORE);
         end
         ST_WRITEBACK: begin
            w_regf_wr = 1'b1;
            w_retire  = 1'b1;
            if (w_cls == CLS_LOAD) begin
               w_rd_src = RD_SRC_MEM;
            end else if (w_cls == CLS_JAL || w_cls == CLS_JALR) begin
               w_rd_src = RD_SRC_PC4;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_FETCH;
         opcode_q  <= '0;
         trap_q    <= 1'b0;
         bus_err_q <= 1'b0;
         instret_q <= '0;
      end else begin
         if (w_retire) begin
            instret_q <= instret_q + InstretWidth'(1);
         end
         case (state_q)
            ST_FETCH: begin
               // A completion in the timeout cycle takes priority over the trap
               if (mem_ready_i) begin
                  state_q <= ST_DECODE;
               end else if (w_timeout) begin
                  state_q   <= ST_TRAP;
                  trap_q    <= 1'b1;
                  bus_err_q <= 1'b1;
               end
            end
            ST_DECODE: begin
               opcode_q <= op_code_i;
               if (classify(op_code_i) == CLS_ILLEGAL) begin
                  state_q <= ST_TRAP;
                  trap_q  <= 1'b1;
               end else begin
                  state_q <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               case (w_cls)
                  CLS_BRANCH:          state_q <= ST_FETCH;
                  CLS_LOAD, CLS_STORE: state_q <= ST_MEMORY;
                  default:             state_q <= ST_WRITEBACK;
               endcase
            end
            ST_MEMORY: begin
               if (mem_ready_i) begin
                  state_q <= (w_cls == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
               end else if (w_timeout) begin
                  state_q   <= ST_TRAP;
                  trap_q    <= 1'b1;
                  bus_err_q <= 1'b1;
               end
            end
            ST_WRITEBACK: state_q <= ST_FETCH;
            default:      state_q <= ST_TRAP;
         endcase
      end
   end

   // Enables are forced low while reset is held, independent of the clock
   assign mem_req_o      = w_mem_req & rst_ni;
   assign mem_wr_en_o    = w_mem_wr & rst_ni;
   assign addr_sel_o     = w_addr_sel;
   assign ir_wr_en_o     = w_ir_wr & rst_ni;
   assign pc_wr_en_o     = w_pc_wr & rst_ni;
   assign regf_wr_en_o   = w_regf_wr & rst_ni;
   assign pc_src_o       = w_pc_src;
   assign alu_src1_sel_o = w_alu1;
   assign alu_src2_sel_o = w_alu2;
   assign regf_rd_src_o  = w_rd_src;
   assign retire_o       = w_retire & rst_ni;
   assign instret_o      = instret_q;
   assign trap_o         = trap_q;
   assign bus_err_o      = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_controller: directed vector bench for the control FSM   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_multicycle_controller;
   import mc_pkg::*;

   localparam int unsigned TIMEOUT   = 4;
   localparam int unsigned INSTRET_W = 4;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic [6:0]           op_code_i = '0;
   logic                 mem_ready_i = 1'b0;
   logic                 branch_taken_i = 1'b0;
   logic                 mem_req_o, mem_wr_en_o, addr_sel_o;
   logic                 ir_wr_en_o, pc_wr_en_o, regf_wr_en_o, pc_src_o;
   logic [1:0]           alu_src1_sel_o, alu_src2_sel_o, regf_rd_src_o;
   logic                 retire_o, trap_o, bus_err_o;
   logic [INSTRET_W-1:0] instret_o;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   multicycle_controller #(
      .TimeoutCycles (TIMEOUT),
      .InstretWidth  (INSTRET_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .op_code_i      (op_code_i),
      .mem_ready_i    (mem_ready_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_o      (mem_req_o),
      .mem_wr_en_o    (mem_wr_en_o),
      .addr_sel_o     (addr_sel_o),
      .ir_wr_en_o     (ir_wr_en_o),
      .pc_wr_en_o     (pc_wr_en_o),
      .regf_wr_en_o   (regf_wr_en_o),
      .pc_src_o       (pc_src_o),
      .alu_src1_sel_o (alu_src1_sel_o),
      .alu_src2_sel_o (alu_src2_sel_o),
      .regf_rd_src_o  (regf_rd_src_o),
      .retire_o       (retire_o),
      .instret_o      (instret_o),
      .trap_o         (trap_o),
      .bus_err_o      (bus_err_o)
   );

   typedef struct {
      logic [6:0] op;
      logic       taken;
      int         lat;
      int         pcw;
      int         rsrc;   // 3 = no register write expected
      int         memw;
      int         a1;
      int         a2;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk_i);
      rst_ni      = 1'b0;
      mem_ready_i = 1'b0;
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
   endtask

   // Runs one instruction; fw/mw = stall cycles on the fetch / data request
   task automatic run_instr(input logic [6:0] op, input logic taken, input int fw, input int mw,
                            input bit do_reset, output int lat, output int pcw, output int rsrc,
                            output int memw, output int a1, output int a2, output int viol);
      int wf, wm, nreq;
      wf = fw; wm = mw; nreq = 0;
      lat = -1; pcw = 0; rsrc = 3; memw = 0; a1 = -1; a2 = -1; viol = 0;
      if (do_reset) reset_dut();
      op_code_i      = op;
      branch_taken_i = taken;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk_i);
         mem_ready_i = 1'b1;
         if (mem_req_o) begin
            if (nreq == 0 && wf > 0) begin
               mem_ready_i = 1'b0;
               wf--;
            end else if (nreq == 1 && wm > 0) begin
               mem_ready_i = 1'b0;
               wm--;
            end
         end
         #1;
         if (mem_req_o && mem_ready_i) nreq++;
         if (pc_wr_en_o) pcw++;
         if (regf_wr_en_o) rsrc = int'(regf_rd_src_o);
         if (mem_wr_en_o) memw++;
         if ((mem_wr_en_o && !mem_req_o) || (ir_wr_en_o && regf_wr_en_o)) viol++;
         if (cyc == 3 + fw) begin
            a1 = int'(alu_src1_sel_o);
            a2 = int'(alu_src2_sel_o);
         end
         if (retire_o) begin
            lat = cyc;
            break;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int lat, pcw, rsrc, memw, a1, a2, viol, total;

      vecs[0] = '{OPC_OP,     1'b0, 4, 1, 0, 0, 0, 0};
      vecs[1] = '{OPC_OPIMM,  1'b0, 4, 1, 0, 0, 0, 1};
      vecs[2] = '{OPC_LUI,    1'b0, 4, 1, 0, 0, 2, 1};
      vecs[3] = '{OPC_AUIPC,  1'b0, 4, 1, 0, 0, 1, 1};
      vecs[4] = '{OPC_LOAD,   1'b0, 5, 1, 1, 0, 0, 1};
      vecs[5] = '{OPC_STORE,  1'b0, 4, 1, 3, 1, 0, 1};
      vecs[6] = '{OPC_BRANCH, 1'b0, 3, 1, 3, 0, 1, 1};
      vecs[7] = '{OPC_BRANCH, 1'b1, 3, 2, 3, 0, 1, 1};
      vecs[8] = '{OPC_JAL,    1'b0, 4, 2, 2, 0, 1, 1};
      vecs[9] = '{OPC_JALR,   1'b0, 4, 2, 2, 0, 0, 1};

      // Reset state and abandonment of a completing fetch
      reset_dut();
      mem_ready_i = 1'b1;
      @(negedge clk_i);
      #1;
      check("fetch_req_after_reset", int'(mem_req_o), 1);
      check("fetch_ir_wr", int'(ir_wr_en_o), 1);
      rst_ni = 1'b0;
      #1;
      check("rst_mem_req", int'(mem_req_o), 0);
      check("rst_ir_wr", int'(ir_wr_en_o), 0);
      check("rst_retire", int'(retire_o), 0);
      check("rst_instret", int'(instret_o), 0);
      check("rst_trap", int'(trap_o), 0);
      check("rst_bus_err", int'(bus_err_o), 0);

      for (int i = 0; i < 10; i++) begin
         run_instr(vecs[i].op, vecs[i].taken, 0, 0, 1'b1, lat, pcw, rsrc, memw, a1, a2, viol);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_pc_wr_count", i), pcw, vecs[i].pcw);
         check($sformatf("v%0d_rd_src", i), rsrc, vecs[i].rsrc);
         check($sformatf("v%0d_mem_wr_count", i), memw, vecs[i].memw);
         check($sformatf("v%0d_alu_src1", i), a1, vecs[i].a1);
         check($sformatf("v%0d_alu_src2", i), a2, vecs[i].a2);
         check($sformatf("v%0d_instret", i), int'(instret_o), 1);
         check($sformatf("v%0d_invariants", i), viol, 0);
      end

      // LOAD with two stalls on both requests
      run_instr(OPC_LOAD, 1'b0, 2, 2, 1'b1, lat, pcw, rsrc, memw, a1, a2, viol);
      check("load_wait_latency", lat, 9);
      check("load_wait_rd_src", rsrc, 1);
      check("load_wait_alu_src2", a2, 1);

      // Branch not-taken then taken, back to back
      run_instr(OPC_BRANCH, 1'b0, 0, 0, 1'b1, lat, pcw, rsrc, memw, a1, a2, viol);
      check("br_nt_latency", lat, 3);
      check("br_nt_pc_wr_count", pcw, 1);
      run_instr(OPC_BRANCH, 1'b1, 0, 0, 1'b0, lat, pcw, rsrc, memw, a1, a2, viol);
      check("br_t_latency", lat, 3);
      check("br_t_pc_wr_count", pcw, 2);
      check("br_instret", int'(instret_o), 2);

      // Fetch stalled past the timeout
      reset_dut();
      op_code_i = OPC_OP;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk_i);
         mem_ready_i = 1'b0;
         #1;
         check($sformatf("to_wait%0d_req", c), int'(mem_req_o), 1);
      end
      @(negedge clk_i);
      #1;
      check("to_trap", int'(trap_o), 1);
      check("to_bus_err", int'(bus_err_o), 1);
      check("to_mem_req_idle", int'(mem_req_o), 0);
      check("to_enables_idle", int'({ir_wr_en_o, pc_wr_en_o, regf_wr_en_o, retire_o}), 0);
      mem_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      check("to_absorbing_trap", int'(trap_o), 1);
      check("to_absorbing_req", int'(mem_req_o), 0);

      // Ready on the last allowed stall cycle completes normally
      run_instr(OPC_OP, 1'b0, 3, 0, 1'b1, lat, pcw, rsrc, memw, a1, a2, viol);
      check("to_edge_latency", lat, 7);
      check("to_edge_no_trap", int'(trap_o), 0);
      check("to_edge_instret", int'(instret_o), 1);

      // Illegal opcode traps without bus error, then an asynchronous reset pulse
      run_instr(OPC_OP, 1'b0, 0, 0, 1'b1, lat, pcw, rsrc, memw, a1, a2, viol);
      check("ill_pre_instret", int'(instret_o), 1);
      op_code_i = 7'b0000000;
      @(negedge clk_i);
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      check("ill_trap", int'(trap_o), 1);
      check("ill_bus_err", int'(bus_err_o), 0);
      check("ill_mem_req", int'(mem_req_o), 0);
      #1 rst_ni = 1'b0;
      #1;
      check("ill_rst_trap", int'(trap_o), 0);
      check("ill_rst_instret", int'(instret_o), 0);
      check("ill_rst_mem_req", int'(mem_req_o), 0);
      rst_ni = 1'b1;
      #1;
      check("ill_rst_fetch", int'(mem_req_o), 1);

      // Counter wrap with a 4-bit instret
      reset_dut();
      total = 0;
      for (int k = 0; k < 17; k++) begin
         run_instr(OPC_OP, 1'b0, 0, 0, 1'b0, lat, pcw, rsrc, memw, a1, a2, viol);
         total += lat;
      end
      check("wrap_total_cycles", total, 68);
      check("wrap_instret", int'(instret_o), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
